// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between the instruction-fetch and data ports.
// Data requests win by default. A saturating counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [DATA_WIDTH-1:0] if_addr_i,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  if_valid_o,
  input  logic                  d_req_i,
  input  logic                  d_wr_en_i,
  input  logic [DATA_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  input  logic [3:0]            d_byte_en_i,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  d_valid_o,
  output logic                  mem_req_o,
  output logic                  mem_wr_en_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_byte_en_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ready_i,
  output logic                  stall_f_o,
  output logic                  stall_m_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t                state, state_next;
  logic [3:0]            starve_cnt, starve_cnt_next;
  logic                  mem_req_next, mem_wr_en_next;
  logic [DATA_WIDTH-1:0] mem_addr_next, mem_wdata_next;
  logic [3:0]            mem_byte_en_next;
  logic [DATA_WIDTH-1:0] if_rdata_next, d_rdata_next;
  logic                  if_valid_next, d_valid_next;

  logic done, free, if_cand, d_cand, grant_i, grant_d;

  assign stall_f_o = if_req_i & ~if_valid_o;
  assign stall_m_o = d_req_i & ~d_valid_o;

  // A request still held high during its own valid pulse is already served,
  // so the stall terms double as "pending" qualifiers.
  assign done    = ((state == BUSY_I) || (state == BUSY_D)) && mem_ready_i;
  assign free    = (state == IDLE) || done;
  assign if_cand = stall_f_o && (state != BUSY_I);
  assign d_cand  = stall_m_o && (state != BUSY_D);
  assign grant_i = free && if_cand && (!d_cand || (starve_cnt == LIMIT));
  assign grant_d = free && d_cand && !grant_i;

  always_comb begin
    state_next       = state;
    starve_cnt_next  = starve_cnt;
    mem_req_next     = mem_req_o;
    mem_wr_en_next   = mem_wr_en_o;
    mem_addr_next    = mem_addr_o;
    mem_wdata_next   = mem_wdata_o;
    mem_byte_en_next = mem_byte_en_o;
    if_rdata_next    = if_rdata_o;
    d_rdata_next     = d_rdata_o;
    if_valid_next    = 1'b0;
    d_valid_next     = 1'b0;

    if (done) begin
      if (state == BUSY_I) begin
        if_valid_next = 1'b1;
        if_rdata_next = mem_rdata_i;
      end else begin
        d_valid_next = 1'b1;
        if (!mem_wr_en_o) begin
          d_rdata_next = mem_rdata_i;
        end
      end
    end

    if (grant_i) begin
      state_next       = BUSY_I;
      mem_req_next     = 1'b1;
      mem_wr_en_next   = 1'b0;
      mem_addr_next    = if_addr_i;
      mem_byte_en_next = 4'hF;
      starve_cnt_next  = 4'd0;
    end else if (grant_d) begin
      state_next       = BUSY_D;
      mem_req_next     = 1'b1;
      mem_wr_en_next   = d_wr_en_i;
      mem_addr_next    = d_addr_i;
      mem_wdata_next   = d_wdata_i;
      mem_byte_en_next = d_byte_en_i;
      if (!if_req_i) begin
        starve_cnt_next = 4'd0;
      end else if (starve_cnt < LIMIT) begin
        starve_cnt_next = starve_cnt + 4'd1;
      end
    end else if (done) begin
      state_next   = IDLE;
      mem_req_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      starve_cnt    <= 4'd0;
      mem_req_o     <= 1'b0;
      mem_wr_en_o   <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      mem_byte_en_o <= 4'd0;
      if_rdata_o    <= '0;
      d_rdata_o     <= '0;
      if_valid_o    <= 1'b0;
      d_valid_o     <= 1'b0;
    end else begin
      state         <= state_next;
      starve_cnt    <= starve_cnt_next;
      mem_req_o     <= mem_req_next;
      mem_wr_en_o   <= mem_wr_en_next;
      mem_addr_o    <= mem_addr_next;
      mem_wdata_o   <= mem_wdata_next;
      mem_byte_en_o <= mem_byte_en_next;
      if_rdata_o    <= if_rdata_next;
      d_rdata_o     <= d_rdata_next;
      if_valid_o    <= if_valid_next;
      d_valid_o     <= d_valid_next;
    end
  end

endmodule
